// File: rtl/bht_update_gen.sv
// Closes the perceptron BHT loop: queues frontend conditional-branch predictions in order,
// matches each in-order resolution against the head and emits a registered {valid, pc, taken, mispredict} update.
module bht_update_gen #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned VLEN      = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     debug_mode_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [VLEN-1:0]          push_pc_i,
  input  logic                     push_taken_i,
  input  logic                     resolve_valid_i,
  input  logic [VLEN-1:0]          resolve_pc_i,
  input  logic                     resolve_taken_i,
  output logic [VLEN+2:0]          bht_update_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [CNT_WIDTH-1:0]     update_cnt_o,
  output logic [CNT_WIDTH-1:0]     mispredict_cnt_o,
  output logic                     desync_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]          PtrOne = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [AW:0]          r_wptr, r_rptr;
  logic [VLEN-1:0]      r_mem_pc [DEPTH];
  logic [DEPTH-1:0]     r_mem_taken;
  logic                 r_upd_valid, r_upd_taken, r_upd_mispredict;
  logic [VLEN-1:0]      r_upd_pc;
  logic [CNT_WIDTH-1:0] r_upd_cnt, r_mis_cnt;
  logic                 r_desync;

  logic            w_empty, w_full, w_push, w_match, w_mispredict;
  logic            w_pop, w_clear, w_emit, w_head_taken;
  logic [VLEN-1:0] w_head_pc;

  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign push_ready_o = !w_full;

  assign w_head_pc    = r_mem_pc[r_rptr[AW-1:0]];
  assign w_head_taken = r_mem_taken[r_rptr[AW-1:0]];
  assign w_match      = !w_empty && (w_head_pc == resolve_pc_i);

  // Empty queue behaves as a default not-taken prediction; a pc mismatch is always a mispredict.
  always_comb begin
    w_mispredict = 1'b1;
    if (w_match)      w_mispredict = (w_head_taken != resolve_taken_i);
    else if (w_empty) w_mispredict = resolve_taken_i;
  end

  assign w_pop   = resolve_valid_i && w_match;
  assign w_clear = flush_i || (resolve_valid_i && w_mispredict);
  assign w_push  = push_valid_i && !w_full && !w_clear;
  assign w_emit  = resolve_valid_i && !debug_mode_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wptr[AW-1:0]]    <= push_pc_i;
      r_mem_taken[r_wptr[AW-1:0]] <= push_taken_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_taken      <= 1'b0;
      r_upd_mispredict <= 1'b0;
      r_upd_cnt        <= '0;
      r_mis_cnt        <= '0;
      r_desync         <= 1'b0;
    end else begin
      r_upd_valid <= w_emit;
      if (resolve_valid_i) begin
        r_upd_pc         <= resolve_pc_i;
        r_upd_taken      <= resolve_taken_i;
        r_upd_mispredict <= w_mispredict;
        if (!w_empty && !w_match) r_desync <= 1'b1;
      end
      if (w_emit && !(&r_upd_cnt)) r_upd_cnt <= r_upd_cnt + CntOne;
      if (w_emit && w_mispredict && !(&r_mis_cnt)) r_mis_cnt <= r_mis_cnt + CntOne;
    end
  end

  assign bht_update_o     = {r_upd_valid, r_upd_pc, r_upd_taken, r_upd_mispredict};
  assign occupancy_o      = r_wptr - r_rptr;
  assign update_cnt_o     = r_upd_cnt;
  assign mispredict_cnt_o = r_mis_cnt;
  assign desync_o         = r_desync;

endmodule

// File: tb/tb_bht_update_gen.sv
// Directed bench for bht_update_gen: each task drives one scenario and checks hand-computed results.
module tb_bht_update_gen;

  localparam int VLEN = 64;
  localparam int DEPTH = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni, flush_i, debug_mode_i;
  logic            push_valid_i, push_taken_i, push_ready_o;
  logic [VLEN-1:0] push_pc_i, resolve_pc_i;
  logic            resolve_valid_i, resolve_taken_i;
  logic [VLEN+2:0] bht_update_o;
  logic [3:0]      occupancy_o;
  logic [15:0]     update_cnt_o, mispredict_cnt_o;
  logic            desync_o;

  logic            uValid, uTaken, uMis;
  logic [VLEN-1:0] uPc;
  assign uValid = bht_update_o[VLEN+2];
  assign uPc    = bht_update_o[VLEN+1:2];
  assign uTaken = bht_update_o[1];
  assign uMis   = bht_update_o[0];

  int checks = 0;
  int failures = 0;

  bht_update_gen #(.DEPTH(DEPTH), .CNT_WIDTH(16), .VLEN(VLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
    .push_taken_i(push_taken_i), .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i), .bht_update_o(bht_update_o), .occupancy_o(occupancy_o),
    .update_cnt_o(update_cnt_o), .mispredict_cnt_o(mispredict_cnt_o), .desync_o(desync_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; debug_mode_i = 0; push_valid_i = 0; push_pc_i = '0; push_taken_i = 0;
    resolve_valid_i = 0; resolve_pc_i = '0; resolve_taken_i = 0;
  endtask

  task automatic push(input logic [VLEN-1:0] pc, input logic taken);
    idle(); push_valid_i = 1; push_pc_i = pc; push_taken_i = taken; tick(); idle();
  endtask

  task automatic resolve(input logic [VLEN-1:0] pc, input logic taken);
    idle(); resolve_valid_i = 1; resolve_pc_i = pc; resolve_taken_i = taken; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst_ni = 0; #12; rst_ni = 1; tick();
    checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL reset_occ actual=%0d required=0", occupancy_o); end
    checks++; if (push_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b required=1", push_ready_o); end
    checks++; if (bht_update_o !== '0) begin failures++; $display("FAIL reset_update actual=%h required=0", bht_update_o); end
    checks++; if (update_cnt_o !== 16'd0 || mispredict_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt actual=%0d/%0d required=0/0", update_cnt_o, mispredict_cnt_o); end
    checks++; if (desync_o !== 1'b0) begin failures++; $display("FAIL reset_desync actual=%b required=0", desync_o); end
  endtask

  task automatic test_match();
    push(64'h100, 1);
    checks++; if (occupancy_o !== 4'd1) begin failures++; $display("FAIL match_occ1 actual=%0d required=1", occupancy_o); end
    resolve(64'h100, 1);
    checks++; if (uValid !== 1 || uMis !== 0 || uTaken !== 1 || uPc !== 64'h100) begin failures++; $display("FAIL match_update actual=v%b m%b t%b pc%h required=v1 m0 t1 pc100", uValid, uMis, uTaken, uPc); end
    checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL match_occ0 actual=%0d required=0", occupancy_o); end
    checks++; if (update_cnt_o !== 16'd1) begin failures++; $display("FAIL match_cnt actual=%0d required=1", update_cnt_o); end
    tick();
    checks++; if (uValid !== 0) begin failures++; $display("FAIL match_valid_drop actual=%b required=0", uValid); end
  endtask

  task automatic test_mispredict();
    push(64'h100, 1); push(64'h104, 0); push(64'h108, 1);
    checks++; if (occupancy_o !== 4'd3) begin failures++; $display("FAIL mis_occ3 actual=%0d required=3", occupancy_o); end
    resolve(64'h100, 0);
    checks++; if (uValid !== 1 || uMis !== 1) begin failures++; $display("FAIL mis_update actual=v%b m%b required=v1 m1", uValid, uMis); end
    checks++; if (occupancy_o !== 4'd0) begin failures++; $display("FAIL mis_occ0 actual=%0d required=0", occupancy_o); end
    checks++; if (mispredict_cnt_o !== 16'd1 || update_cnt_o !== 16'd2) begin failures++; $display("FAIL mis_cnt actual=%0d/%0d required=2/1", update_cnt_o, mispredict_cnt_o); end
    resolve(64'h200, 1);
    checks++; if (uValid !== 1 || uMis !== 1 || uPc !== 64'h200) begin failures++; $display("FAIL empty_update actual=v%b m%b pc%h required=v1 m1 pc200", uValid, uMis, uPc); end
    checks++; if (mispredict_cnt_o !== 16'd2 || update_cnt_o !== 16'd3 || desync_o !== 0) begin failures++; $display("FAIL empty_cnt actual=%0d/%0d d%b required=3/2 d0", update_cnt_o, mispredict_cnt_o, desync_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) push(64'h400 + 64'(4 * i), 0);
    checks++; if (push_ready_o !== 0 || occupancy_o !== 4'd8) begin failures++; $display("FAIL full_state actual=r%b occ%0d required=r0 occ8", push_ready_o, occupancy_o); end
    push(64'h480, 0);
    checks++; if (occupancy_o !== 4'd8) begin failures++; $display("FAIL full_ignore actual=%0d required=8", occupancy_o); end
    idle();
    push_valid_i = 1; push_pc_i = 64'h500; resolve_valid_i = 1; resolve_pc_i = 64'h400; resolve_taken_i = 0;
    #1;
    checks++; if (push_ready_o !== 0) begin failures++; $display("FAIL full_pop_ready actual=%b required=0", push_ready_o); end
    tick(); idle();
    checks++; if (occupancy_o !== 4'd7 || uValid !== 1 || uMis !== 0) begin failures++; $display("FAIL full_pop actual=occ%0d v%b m%b required=occ7 v1 m0", occupancy_o, uValid, uMis); end
    resolve(64'h404, 0);
    checks++; if (uMis !== 0 || occupancy_o !== 4'd6) begin failures++; $display("FAIL full_order actual=m%b occ%0d required=m0 occ6", uMis, occupancy_o); end
    flush_i = 1; tick(); idle();
    checks++; if (occupancy_o !== 4'd0 || uValid !== 0) begin failures++; $display("FAIL full_flush actual=occ%0d v%b required=occ0 v0", occupancy_o, uValid); end
  endtask

  task automatic test_desync();
    push(64'h100, 1);
    resolve(64'h300, 1);
    checks++; if (desync_o !== 1 || uMis !== 1 || occupancy_o !== 4'd0) begin failures++; $display("FAIL desync_set actual=d%b m%b occ%0d required=d1 m1 occ0", desync_o, uMis, occupancy_o); end
    push(64'h104, 1);
    resolve(64'h104, 1);
    checks++; if (desync_o !== 1 || uMis !== 0) begin failures++; $display("FAIL desync_sticky actual=d%b m%b required=d1 m0", desync_o, uMis); end
    checks++; if (update_cnt_o !== 16'd7 || mispredict_cnt_o !== 16'd3) begin failures++; $display("FAIL desync_cnt actual=%0d/%0d required=7/3", update_cnt_o, mispredict_cnt_o); end
  endtask

  task automatic test_debug();
    push(64'h120, 0); push(64'h124, 0);
    idle(); debug_mode_i = 1; resolve_valid_i = 1; resolve_pc_i = 64'h120; resolve_taken_i = 0;
    tick(); idle();
    checks++; if (uValid !== 0 || occupancy_o !== 4'd1) begin failures++; $display("FAIL debug_pop actual=v%b occ%0d required=v0 occ1", uValid, occupancy_o); end
    checks++; if (update_cnt_o !== 16'd7 || mispredict_cnt_o !== 16'd3) begin failures++; $display("FAIL debug_cnt actual=%0d/%0d required=7/3", update_cnt_o, mispredict_cnt_o); end
    resolve(64'h124, 0);
    checks++; if (uValid !== 1 || occupancy_o !== 4'd0 || update_cnt_o !== 16'd8) begin failures++; $display("FAIL debug_after actual=v%b occ%0d c%0d required=v1 occ0 c8", uValid, occupancy_o, update_cnt_o); end
  endtask

  task automatic test_back_to_back();
    push(64'h10, 1);
    idle(); push_valid_i = 1; push_pc_i = 64'h14; push_taken_i = 1;
    resolve_valid_i = 1; resolve_pc_i = 64'h10; resolve_taken_i = 1;
    tick(); idle();
    checks++; if (occupancy_o !== 4'd1 || uMis !== 0) begin failures++; $display("FAIL b2b_occ actual=occ%0d m%b required=occ1 m0", occupancy_o, uMis); end
    resolve(64'h14, 1);
    checks++; if (occupancy_o !== 4'd0 || uMis !== 0 || update_cnt_o !== 16'd10) begin failures++; $display("FAIL b2b_second actual=occ%0d m%b c%0d required=occ0 m0 c10", occupancy_o, uMis, update_cnt_o); end
    idle(); push_valid_i = 1; push_pc_i = 64'h40; resolve_valid_i = 1; resolve_pc_i = 64'h50; resolve_taken_i = 0;
    tick(); idle();
    checks++; if (occupancy_o !== 4'd1 || uMis !== 0 || uValid !== 1) begin failures++; $display("FAIL empty_push_resolve actual=occ%0d m%b v%b required=occ1 m0 v1", occupancy_o, uMis, uValid); end
    resolve(64'h40, 0);
    checks++; if (occupancy_o !== 4'd0 || uMis !== 0 || desync_o !== 1) begin failures++; $display("FAIL stored_entry actual=occ%0d m%b required=occ0 m0", occupancy_o, uMis); end
  endtask

  task automatic test_flush();
    push(64'h20, 0); push(64'h24, 0); push(64'h28, 0);
    idle(); flush_i = 1; push_valid_i = 1; push_pc_i = 64'h2c;
    tick(); idle();
    checks++; if (occupancy_o !== 4'd0 || uValid !== 0) begin failures++; $display("FAIL flush_push actual=occ%0d v%b required=occ0 v0", occupancy_o, uValid); end
    push(64'h30, 1);
    idle(); flush_i = 1; resolve_valid_i = 1; resolve_pc_i = 64'h30; resolve_taken_i = 1;
    tick(); idle();
    checks++; if (uValid !== 1 || uMis !== 0 || occupancy_o !== 4'd0 || update_cnt_o !== 16'd13) begin failures++; $display("FAIL flush_resolve actual=v%b m%b occ%0d c%0d required=v1 m0 occ0 c13", uValid, uMis, occupancy_o, update_cnt_o); end
  endtask

  task automatic test_saturation();
    idle(); resolve_valid_i = 1; resolve_pc_i = 64'h700; resolve_taken_i = 0;
    repeat (65530) @(posedge clk_i);
    #1; idle();
    checks++; if (update_cnt_o !== 16'hFFFF || mispredict_cnt_o !== 16'd3) begin failures++; $display("FAIL sat_reach actual=%h/%0d required=ffff/3", update_cnt_o, mispredict_cnt_o); end
    resolve(64'h704, 0);
    checks++; if (update_cnt_o !== 16'hFFFF || uValid !== 1) begin failures++; $display("FAIL sat_hold actual=%h v%b required=ffff v1", update_cnt_o, uValid); end
  endtask

  task automatic test_reset_mid();
    push(64'h60, 1);
    idle(); resolve_valid_i = 1; resolve_pc_i = 64'h60; resolve_taken_i = 1;
    @(negedge clk_i); rst_ni = 0; #1;
    checks++; if (occupancy_o !== 4'd0 || update_cnt_o !== 16'd0 || desync_o !== 0) begin failures++; $display("FAIL rst_async actual=occ%0d c%0d d%b required=0 0 0", occupancy_o, update_cnt_o, desync_o); end
    tick(); idle(); rst_ni = 1; tick();
    checks++; if (uValid !== 0 || bht_update_o !== '0 || mispredict_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_lost actual=%h m%0d required=0 0", bht_update_o, mispredict_cnt_o); end
  endtask

  initial begin
    rst_ni = 1; idle();
    test_reset();
    test_match();
    test_mispredict();
    test_full();
    test_desync();
    test_debug();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bht_update_gen.md
Name: bht_update_gen

Overview:
- Backend-side producer of ariane_pkg::bht_update_t for the perceptron BHT. It closes the loop from branch resolution back to the predictor.
- Holds an in-order queue of the frontend's conditional-branch predictions (pc and predicted direction).
- Matches each in-order resolution from the branch unit against the queue head, then emits a registered update carrying valid, pc, taken and mispredict.
- Flushes wrong-path queue entries on a mispredict and keeps saturating statistics counters.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous queue clear (pipeline flush).
- debug_mode_i  in  1  suppresses update emission; queue still pops.
- push_valid_i  in  1  frontend presents a predicted conditional branch.
- push_ready_o  out  1  queue not full.
- push_pc_i  in  riscv::VLEN  pc of the predicted branch.
- push_taken_i  in  1  predicted direction.
- resolve_valid_i  in  1  branch resolved; resolutions arrive in program order.
- resolve_pc_i  in  riscv::VLEN  pc of the resolved branch.
- resolve_taken_i  in  1  actual direction.
- bht_update_o  out  ariane_pkg::bht_update_t  registered update (valid, pc, taken, mispredict).
- occupancy_o  out  $clog2(DEPTH)+1  current entry count.
- update_cnt_o  out  CNT_WIDTH  emitted updates, saturating.
- mispredict_cnt_o  out  CNT_WIDTH  emitted mispredicts, saturating.
- desync_o  out  1  sticky flag: a resolve pc did not match the head pc.

Behaviour:
- Reset:
  - Queue empty; read/write pointers 0; occupancy_o=0; push_ready_o=1.
  - bht_update_o all fields 0; both counters 0; desync_o=0.
- Storage: circular buffer of {pc, pred_taken}. Pointers have one extra wrap bit. Full when pointer indices are equal and wrap bits differ; empty when both are equal.
- Push is accepted when push_valid_i && push_ready_o. push_ready_o is combinational: !full.
- A resolve is processed every cycle resolve_valid_i=1. It is never back-pressured. Cases:
  - (a) Queue non-empty and head.pc == resolve_pc_i: pop the head. mispredict = head.pred_taken != resolve_taken_i.
  - (b) Queue empty: treated as an unpredicted branch with default prediction not-taken. mispredict = resolve_taken_i. Nothing is popped.
  - (c) Queue non-empty and pc mismatch: mispredict=1, desync_o is set (sticky until reset), and the whole queue is cleared.
- Wrong-path clear:
  - If the processed resolve has mispredict=1, all entries younger than the popped head are discarded in the same cycle. Next-cycle occupancy is 0.
  - A push in that same cycle is dropped, because it is wrong path.
- Update output:
  - bht_update_o is registered. valid=1 exactly one cycle after a processed resolve, with pc=resolve_pc_i, taken=resolve_taken_i and mispredict as computed. valid=0 otherwise.
  - If debug_mode_i=1 on the resolve cycle, valid=0 the next cycle. The queue still pops or clears, and the counters do not increment.
- Simultaneous push and resolve without a clear: both take effect; occupancy is unchanged.
- Push into empty with resolve in the same cycle: no bypass. The resolve takes case (b) and the pushed entry is stored.
- Full with a resolve pop in the same cycle: push_ready_o is still 0. No push is accepted that cycle.
- flush_i:
  - Clears the queue at the clock edge. It takes priority over a same-cycle push, which is dropped.
  - A same-cycle resolve is still evaluated against the pre-flush head, and its update is emitted.
- Counters: update_cnt_o increments on each emitted valid update; mispredict_cnt_o increments on each emitted update with mispredict=1. Both saturate at all-ones.
- Reset asserted mid-operation: all state returns immediately to reset values, and any pending update is lost.

Test Plan:
- Push pc=0x100 taken=1, then resolve pc=0x100 taken=1 → next cycle update valid=1, mispredict=0; occupancy 0; update_cnt=1.
- Push 0x100 T, 0x104 N, 0x108 T; resolve 0x100 taken=0 → update mispredict=1; occupancy 0; mispredict_cnt=1; then resolve 0x200 taken=1 on empty queue → mispredict=1.
- Push DEPTH=8 entries → push_ready_o=0 and a 9th push is ignored. Same-cycle resolve matching the head plus a push → push still rejected, occupancy 7.
- Push 0x100; resolve pc=0x300 → desync_o=1 and stays 1; update mispredict=1; queue cleared.
- debug_mode_i=1 during resolve of the matching head → no update valid, counters unchanged, occupancy decremented.
- Force update_cnt to 0xFFFF via 65535 resolves, then one more → remains 0xFFFF. flush_i with queue at 3 plus a same-cycle push → occupancy 0.
